// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared programmable-period counter, edge/centre alignment,
// and double-buffered, handshaked duty updates applied only at period boundaries.
module pwm_multi #(
    parameter int NUM_CH        = 2,
    parameter int INPUT_WIDTH   = 12,
    parameter int COUNTER_WIDTH = 10,
    parameter int OFFSET        = 512
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          enable,
    input  logic [COUNTER_WIDTH-1:0]      period,
    input  logic                          center_mode,
    input  logic [NUM_CH*INPUT_WIDTH-1:0] data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic [NUM_CH-1:0]             pwm_out,
    output logic                          period_start
);
    localparam int SW = INPUT_WIDTH + 2;
    localparam int DW = COUNTER_WIDTH + 1;
    localparam int EW = (SW > DW + 1) ? SW : DW + 1;

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    logic [COUNTER_WIDTH-1:0]      count, count_nxt, period_sh, eff_p;
    dir_t                          dir, dir_nxt;
    logic                          mode_sh, eff_mode, boundary, accept, pending_valid;
    logic [NUM_CH*INPUT_WIDTH-1:0] pending;
    logic [DW-1:0]                 duty_sh  [NUM_CH];
    logic [DW-1:0]                 duty_eff [NUM_CH];

    // Duty is one bit wider than the counter so that P+1 (constant high) is representable.
    function automatic logic [DW-1:0] saturate(input logic [INPUT_WIDTH-1:0] sample,
                                               input logic [COUNTER_WIDTH-1:0] p);
        logic signed [EW-1:0] d;
        logic signed [EW-1:0] lim;
        d   = EW'(signed'(sample)) + EW'(OFFSET);
        lim = signed'(EW'(p));
        if (d < 0)
            return '0;
        else if (d > lim)
            return DW'(p) + DW'(1);
        else
            return DW'(d);
    endfunction

    assign data_ready = !pending_valid;
    assign accept     = data_valid && !pending_valid;
    assign boundary   = enable && (count == '0) && (!mode_sh || dir == DIR_UP);
    assign eff_p      = boundary ? period : period_sh;
    assign eff_mode   = boundary ? center_mode : mode_sh;

    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            duty_eff[k] = (boundary && pending_valid)
                        ? saturate(pending[k*INPUT_WIDTH +: INPUT_WIDTH], period)
                        : duty_sh[k];
        end
    end

    // Centre mode: climb to P, then descend; direction returns to up whenever count reaches 0.
    always_comb begin
        count_nxt = count;
        dir_nxt   = dir;
        if (!eff_mode) begin
            dir_nxt   = DIR_UP;
            count_nxt = (count >= eff_p) ? '0 : count + 1'b1;
        end else if (dir == DIR_UP && count < eff_p) begin
            count_nxt = count + 1'b1;
        end else begin
            count_nxt = (count == '0) ? '0 : count - 1'b1;
            dir_nxt   = (count_nxt == '0) ? DIR_UP : DIR_DOWN;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count         <= '0;
            dir           <= DIR_UP;
            period_sh     <= '0;
            mode_sh       <= 1'b0;
            pending       <= '0;
            pending_valid <= 1'b0;
            pwm_out       <= '0;
            period_start  <= 1'b0;
            for (int unsigned k = 0; k < NUM_CH; k++) duty_sh[k] <= '0;
        end else begin
            if (accept) begin
                pending       <= data_in;
                pending_valid <= 1'b1;
            end else if (boundary && pending_valid) begin
                pending_valid <= 1'b0;
            end

            if (!enable) begin
                count        <= '0;
                dir          <= DIR_UP;
                pwm_out      <= '0;
                period_start <= 1'b0;
            end else begin
                count        <= count_nxt;
                dir          <= dir_nxt;
                period_start <= boundary;
                for (int unsigned k = 0; k < NUM_CH; k++)
                    pwm_out[k] <= (DW'(count) < duty_eff[k]);
                if (boundary) begin
                    period_sh <= period;
                    mode_sh   <= center_mode;
                    for (int unsigned k = 0; k < NUM_CH; k++) duty_sh[k] <= duty_eff[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: a table of steady-state period measurements plus
// hand-written reset, handshake, enable and mid-period reconfiguration sequences.
module tb_pwm_multi;
    localparam int LIMIT = 3000;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic        enable = 1'b0;
    logic [9:0]  period = '0;
    logic        center_mode = 1'b0;
    logic [23:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [1:0]  pwm_out;
    logic        period_start;

    int total = 0;
    int bad = 0;
    logic [1:0] prev = '0;

    typedef struct {
        logic signed [11:0] s0, s1;
        logic [9:0]         per;
        logic               mode;
        int                 len, h0, h1, r0, r1;
    } vec_t;

    vec_t vecs[8];

    pwm_multi #(.NUM_CH(2), .INPUT_WIDTH(12), .COUNTER_WIDTH(10), .OFFSET(512)) dut (
        .clk(clk), .arst(arst), .enable(enable), .period(period), .center_mode(center_mode),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .pwm_out(pwm_out), .period_start(period_start)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int s0, int s1, int per, int mode,
                                int len, int h0, int h1, int r0, int r1);
        vec_t v;
        v.s0 = 12'(s0); v.s1 = 12'(s1); v.per = 10'(per); v.mode = mode[0];
        v.len = len; v.h0 = h0; v.h1 = h1; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input string name, input int s0, input int s1);
        int n;
        n = 0;
        while (!data_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready"}, int'(data_ready), 1);
        data_in    = {12'(s1), 12'(s0)};
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!period_start) prev = pwm_out;
        end while (!period_start && n < LIMIT);
        check({name, "_start_seen"}, int'(period_start), 1);
    endtask

    // Called on a negedge where period_start is high; measures n consecutive periods.
    task automatic measure(input string name, input int n_per, input int len_e,
                           input int h0_e, input int h1_e, input int r0_e, input int r1_e);
        int len, h0, h1, r0, r1;
        for (int p = 0; p < n_per; p++) begin
            len = 0; h0 = 0; h1 = 0; r0 = 0; r1 = 0;
            do begin
                h0 += int'(pwm_out[0]);
                h1 += int'(pwm_out[1]);
                r0 += int'(pwm_out[0] && !prev[0]);
                r1 += int'(pwm_out[1] && !prev[1]);
                prev = pwm_out;
                len++;
                @(negedge clk);
            end while (!period_start && len < LIMIT);
            check($sformatf("%s_p%0d_len", name, p), len, len_e);
            check($sformatf("%s_p%0d_high0", name, p), h0, h0_e);
            check($sformatf("%s_p%0d_high1", name, p), h1, h1_e);
            check($sformatf("%s_p%0d_rise0", name, p), r0, r0_e);
            check($sformatf("%s_p%0d_rise1", name, p), r1, r1_e);
        end
    endtask

    initial begin
        int len, h0, h1, stall, leak, quiet;

        vecs[0] = mk(-507,  -510, 9,    0, 10,   5,    2,    1, 1);
        vecs[1] = mk( 100,  -600, 9,    0, 10,   10,   0,    0, 0);
        vecs[2] = mk(-509,  -512, 8,    1, 16,   5,    0,    1, 0);
        vecs[3] = mk(-511,  -504, 8,    1, 16,   1,    15,   1, 1);
        vecs[4] = mk(-2048, -511, 0,    0, 1,    0,    1,    0, 0);
        vecs[5] = mk(-511,  0,    1,    1, 2,    1,    2,    1, 0);
        vecs[6] = mk( 511,  2047, 1023, 0, 1024, 1023, 1024, 1, 0);
        vecs[7] = mk(-513,  -503, 9,    0, 10,   0,    9,    0, 1);

        #2 arst = 1'b1;
        @(negedge clk);
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_pstart", int'(period_start), 0);
        check("rst_ready", int'(data_ready), 1);
        repeat (2) @(negedge clk);
        arst = 1'b0;
        enable = 1'b1;

        for (int i = 0; i < 8; i++) begin
            period      = vecs[i].per;
            center_mode = vecs[i].mode;
            push($sformatf("v%0d", i), int'(vecs[i].s0), int'(vecs[i].s1));
            wait_start($sformatf("v%0d_a", i));
            wait_start($sformatf("v%0d_b", i));
            measure($sformatf("v%0d", i), 3, vecs[i].len, vecs[i].h0, vecs[i].h1,
                    vecs[i].r0, vecs[i].r1);
        end

        // Reset mid-period with a full pending buffer
        period = 10'd9; center_mode = 1'b0;
        push("rs_x", -507, -510);
        wait_start("rs_a");
        wait_start("rs_b");
        repeat (2) @(negedge clk);
        push("rs_y", -505, -505);
        check("rs_pending_full", int'(data_ready), 0);
        arst = 1'b1;
        #1;
        check("rs_async_pwm", int'(pwm_out), 0);
        check("rs_async_ready", int'(data_ready), 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rs_c%0d_pwm", c), int'(pwm_out), 0);
            check($sformatf("rs_c%0d_pstart", c), int'(period_start), 0);
            check($sformatf("rs_c%0d_ready", c), int'(data_ready), 1);
        end
        arst = 1'b0;
        prev = '0;
        wait_start("rs_rel");
        measure("rs_after", 1, 10, 0, 0, 0, 0);

        // Back-to-back beats: A waits for the boundary, B stalls until the cycle after it
        repeat (2) @(negedge clk);
        data_in = {12'(-505), 12'(-509)};
        data_valid = 1'b1;
        @(negedge clk);
        check("bb_a_taken", int'(data_ready), 0);
        data_in = {12'(-511), 12'(-504)};
        stall = 0; leak = 0; len = 0;
        do begin
            @(negedge clk);
            len++;
            if (!period_start) begin
                stall += int'(data_ready);
                leak  += int'(pwm_out != 2'b00);
                prev = pwm_out;
            end
        end while (!period_start && len < LIMIT);
        check("bb_boundary_seen", int'(period_start), 1);
        check("bb_b_stalled", stall, 0);
        check("bb_a_not_early", leak, 0);
        check("bb_ready_at_boundary", int'(data_ready), 1);
        check("bb_a_first_cycle", int'(pwm_out), 3);
        len = 1; h0 = int'(pwm_out[0]); h1 = int'(pwm_out[1]);
        prev = pwm_out;
        @(negedge clk);
        check("bb_b_taken", int'(data_ready), 0);
        data_valid = 1'b0;
        while (!period_start && len < LIMIT) begin
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            prev = pwm_out;
            len++;
            @(negedge clk);
        end
        check("bb_a_len", len, 10);
        check("bb_a_high0", h0, 3);
        check("bb_a_high1", h1, 7);
        measure("bb_b", 1, 10, 8, 1, 1, 1);

        // Disable mid-period; the handshake keeps working and re-enable starts a fresh period
        repeat (2) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        quiet = int'(pwm_out != 2'b00) + int'(period_start);
        push("en", -508, -502);
        check("en_pending_full", int'(data_ready), 0);
        repeat (3) begin
            @(negedge clk);
            quiet += int'(pwm_out != 2'b00) + int'(period_start) + int'(data_ready);
        end
        check("en_quiet", quiet, 0);
        prev = pwm_out;
        enable = 1'b1;
        @(negedge clk);
        check("en_first_boundary", int'(period_start), 1);
        check("en_first_pwm", int'(pwm_out), 3);
        check("en_drained", int'(data_ready), 1);
        measure("en", 1, 10, 4, 10, 1, 1);

        // Mid-period switch P 9->4 and edge->centre, with a duty that saturates
        len = 1;
        repeat (3) begin
            @(negedge clk);
            len++;
        end
        period = 10'd4;
        center_mode = 1'b1;
        data_in = {12'(-510), 12'(-506)};
        data_valid = 1'b1;
        @(negedge clk);
        len++;
        data_valid = 1'b0;
        prev = pwm_out;
        do begin
            @(negedge clk);
            if (!period_start) begin
                len++;
                prev = pwm_out;
            end
        end while (!period_start && len < LIMIT);
        check("mc_old_len", len, 10);
        measure("mc_new0", 1, 8, 8, 3, 1, 1);
        measure("mc_new1", 1, 8, 8, 3, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
